// File: rtl/lsr_seq_pkg.sv
// rtl/lsr_seq_pkg.sv - shared FSM state type and direction encodings for lsr_seq
package lsr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lsr_seq_ctrl.sv
// rtl/lsr_seq_ctrl.sv - sequence FSM and down-counter, emits one step enable per RUN cycle
module lsr_seq_ctrl
    import lsr_seq_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic             step
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                // DONE is not busy, so a start on that edge is honoured like in IDLE
                state_nxt = IDLE;
                if (start) begin
                    cnt_nxt   = amount;
                    state_nxt = (amount == '0) ? DONE : RUN;
                end
            end
        endcase
        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    assign busy = (state == RUN);
    assign step = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: rtl/lsr_seq.sv
// rtl/lsr_seq.sv - shift register with multi-step sequencer; LSR_SEQ_ROTATE_EN adds rotate mode
module lsr_seq
    import lsr_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] in_A,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic             arith,
    input  logic             shift,
    input  logic             load_R0,
    input  logic             in_bit,
`ifdef LSR_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] out_r,
    output logic             out_bit,
    output logic             busy,
    output logic             done
);

    logic             start_acc;
    logic [CNT_W-1:0] amount_clamped;
    logic             step;
    logic             dir_q;
    logic             arith_q;
    logic             rot_q;
    logic [WIDTH-1:0] step_r;
    logic             step_bit;
    logic             fill;

    assign start_acc      = start && !busy && !clr && !load;
    assign amount_clamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

    lsr_seq_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .start  (start_acc),
        .amount (amount_clamped),
        .busy   (busy),
        .done   (done),
        .step   (step)
    );

`ifdef LSR_SEQ_ROTATE_EN
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rot_q <= 1'b0;
        end else if (start_acc) begin
            rot_q <= rot;
        end
    end
`else
    assign rot_q = 1'b0;
`endif

    // Rotate takes precedence over arithmetic fill on right shifts
    always_comb begin
        fill     = 1'b0;
        step_r   = out_r;
        step_bit = out_bit;
        if (dir_q == DIR_LEFT) begin
            step_bit = out_r[WIDTH-1];
            fill     = rot_q & out_r[WIDTH-1];
            step_r   = {out_r[WIDTH-2:0], fill};
        end else begin
            step_bit = out_r[0];
            fill     = rot_q ? out_r[0] : (arith_q & out_r[WIDTH-1]);
            step_r   = {fill, out_r[WIDTH-1:1]};
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            out_r   <= '0;
            out_bit <= 1'b0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
        end else if (clr) begin
            out_r   <= '0;
            out_bit <= 1'b0;
        end else if (busy) begin
            if (step) begin
                out_r   <= step_r;
                out_bit <= step_bit;
            end
        end else if (load) begin
            out_r <= in_A;
        end else if (start) begin
            dir_q   <= dir;
            arith_q <= arith;
        end else if (shift) begin
            out_r   <= {out_r[WIDTH-2:0], 1'b0};
            out_bit <= out_r[WIDTH-1];
        end else if (load_R0) begin
            out_r[0] <= in_bit;
        end
    end

endmodule

// File: tb/tb_lsr_seq.sv
// tb/tb_lsr_seq.sv - scoreboard bench for lsr_seq (WIDTH=16), define LSR_SEQ_ROTATE_EN for rotate tests
module tb_lsr_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr, load, start, dir, arith, shift, load_R0, in_bit;
    logic [15:0] in_A;
    logic [4:0]  amount;
`ifdef LSR_SEQ_ROTATE_EN
    logic        rot;
`endif
    logic [15:0] out_r;
    logic        out_bit, busy, done;

    typedef struct {
        logic [15:0] r;
        logic        b;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl_r;
    logic        mdl_b;

    always #5 clk = ~clk;

    lsr_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .load    (load),
        .in_A    (in_A),
        .start   (start),
        .amount  (amount),
        .dir     (dir),
        .arith   (arith),
        .shift   (shift),
        .load_R0 (load_R0),
        .in_bit  (in_bit),
`ifdef LSR_SEQ_ROTATE_EN
        .rot     (rot),
`endif
        .out_r   (out_r),
        .out_bit (out_bit),
        .busy    (busy),
        .done    (done)
    );

    // DUT updates on negedge; inputs change and outputs are sampled at posedge
    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic void model(input logic [15:0] v, input logic b, input logic d,
                                  input logic a, input logic r, input int n,
                                  output logic [15:0] ov, output logic ob);
        logic [15:0] t;
        logic        o;
        int          k;
        t = v;
        o = b;
        k = (n > 16) ? 16 : n;
        for (int i = 0; i < k; i++) begin
            if (!d) begin
                o = t[15];
                t = t << 1;
                if (r) t[0] = o;
            end else begin
                o = t[0];
                if (a && !r) t = 16'($signed(t) >>> 1);
                else         t = t >> 1;
                if (r) t[15] = o;
            end
        end
        ov = t;
        ob = o;
    endfunction

    task automatic cmd_load(input logic [15:0] v);
        load = 1'b1;
        in_A = v;
        cyc();
        load  = 1'b0;
        mdl_r = v;
    endtask

    task automatic issue(input string name, input logic d, input logic a, input logic r,
                         input int amt, input bit track);
        exp_t e;
        if (track) begin
            model(mdl_r, mdl_b, d, a, r, amt, e.r, e.b);
            e.cycles = (amt > 16) ? 16 : amt;
            e.name   = name;
            exp_q.push_back(e);
        end
        dir    = d;
        arith  = a;
`ifdef LSR_SEQ_ROTATE_EN
        rot    = r;
`endif
        amount = 5'(amt);
        start  = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int pre);
        exp_t e;
        int   busy_n;
        bit   seen;
        busy_n = pre;
        seen   = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_n++;
            cyc();
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done never rose, busy_cycles=%0d", e.name, busy_n);
        end else begin
            checks += 3;
            if (out_r !== e.r) begin
                errors++;
                $display("FAIL %s out_r: got %h want %h", e.name, out_r, e.r);
            end
            if (out_bit !== e.b) begin
                errors++;
                $display("FAIL %s out_bit: got %b want %b", e.name, out_bit, e.b);
            end
            if (busy_n != e.cycles) begin
                errors++;
                $display("FAIL %s busy_cycles: got %0d want %0d", e.name, busy_n, e.cycles);
            end
        end
        mdl_r = e.r;
        mdl_b = e.b;
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", e.name, done, busy);
        end
    endtask

    task automatic watch_no_done(input string name, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            if (done !== 1'b0) hits++;
            cyc();
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL %s no_done: got %0d done cycles want 0", name, hits);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++;
        if (out_r !== 16'h0 || out_bit !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got r=%h b=%b busy=%b done=%b want 0000 0 0 0",
                     out_r, out_bit, busy, done);
        end
        reset = 1'b1;
        cyc();
        mdl_r = 16'h0;
        mdl_b = 1'b0;
    endtask

    task automatic test_left();
        cmd_load(16'h00F0);
        issue("left4", 1'b0, 1'b0, 1'b0, 4, 1);
        wait_done(0);
    endtask

    task automatic test_arith_and_zero();
        cmd_load(16'h8004);
        issue("arith2", 1'b1, 1'b1, 1'b0, 2, 1);
        wait_done(0);
        issue("amount0", 1'b0, 1'b0, 1'b0, 0, 1);
        wait_done(0);
    endtask

    task automatic test_clamp_and_clr();
        cmd_load(16'hFFFF);
        issue("clamp20", 1'b0, 1'b0, 1'b0, 20, 1);
        wait_done(0);
        cmd_load(16'hFFFF);
        issue("clr_abort", 1'b0, 1'b0, 1'b0, 16, 0);
        for (int i = 0; i < 4; i++) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (out_r !== 16'h0 || out_bit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort: got r=%h b=%b busy=%b want 0000 0 0", out_r, out_bit, busy);
        end
        mdl_r = 16'h0;
        mdl_b = 1'b0;
        watch_no_done("clr_abort", 20);
    endtask

    task automatic test_single_step();
        cmd_load(16'h0003);
        shift = 1'b1;
        cyc();
        shift = 1'b0;
        checks++;
        if (out_r !== 16'h0006 || out_bit !== 1'b0) begin
            errors++;
            $display("FAIL shift: got r=%h b=%b want 0006 0", out_r, out_bit);
        end
        load_R0 = 1'b1;
        in_bit  = 1'b1;
        cyc();
        load_R0 = 1'b0;
        in_bit  = 1'b0;
        checks++;
        if (out_r !== 16'h0007) begin
            errors++;
            $display("FAIL load_R0: got %h want 0007", out_r);
        end
        load  = 1'b1;
        shift = 1'b1;
        in_A  = 16'h1234;
        cyc();
        load  = 1'b0;
        shift = 1'b0;
        checks++;
        if (out_r !== 16'h1234) begin
            errors++;
            $display("FAIL load_over_shift: got %h want 1234", out_r);
        end
        cmd_load(16'h8001);
        shift = 1'b1;
        cyc();
        shift = 1'b0;
        checks++;
        if (out_r !== 16'h0002 || out_bit !== 1'b1) begin
            errors++;
            $display("FAIL shift_out_bit: got r=%h b=%b want 0002 1", out_r, out_bit);
        end
        mdl_r = 16'h0002;
        mdl_b = 1'b1;
    endtask

    task automatic test_busy_ignore();
        cmd_load(16'h0001);
        issue("busy_ignore", 1'b0, 1'b0, 1'b0, 3, 1);
        load    = 1'b1;
        in_A    = 16'hFFFF;
        shift   = 1'b1;
        load_R0 = 1'b1;
        in_bit  = 1'b1;
        start   = 1'b1;
        amount  = 5'd9;
        cyc();
        load    = 1'b0;
        shift   = 1'b0;
        load_R0 = 1'b0;
        in_bit  = 1'b0;
        start   = 1'b0;
        wait_done(1);
    endtask

    task automatic test_reset_mid_run();
        cmd_load(16'h1234);
        issue("reset_mid", 1'b1, 1'b0, 1'b0, 10, 0);
        cyc();
        cyc();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_r !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got r=%h busy=%b done=%b want 0000 0 0", out_r, busy, done);
        end
        @(posedge clk);
        reset = 1'b1;
        mdl_r = 16'h0;
        mdl_b = 1'b0;
        watch_no_done("reset_mid_run", 20);
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic        d, a;
        int          n;
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            d = 1'($urandom);
            a = 1'($urandom);
            n = $urandom_range(0, 20);
            cmd_load(v);
            issue("random_seq", d, a, 1'b0, n, 1);
            wait_done(0);
        end
    endtask

`ifdef LSR_SEQ_ROTATE_EN
    task automatic test_rotate();
        cmd_load(16'h8001);
        issue("rot_left1", 1'b0, 1'b0, 1'b1, 1, 1);
        wait_done(0);
        cmd_load(16'h8005);
        issue("rot_right3", 1'b1, 1'b1, 1'b1, 3, 1);
        wait_done(0);
    endtask
`endif

    initial begin
        reset   = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        arith   = 1'b0;
        shift   = 1'b0;
        load_R0 = 1'b0;
        in_bit  = 1'b0;
        in_A    = 16'h0;
        amount  = 5'd0;
`ifdef LSR_SEQ_ROTATE_EN
        rot     = 1'b0;
`endif
        @(posedge clk);
        test_reset();
        test_left();
        test_arith_and_zero();
        test_clamp_and_clr();
        test_single_step();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
`ifdef LSR_SEQ_ROTATE_EN
        test_rotate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsr_seq.md
LSR_SEQ -- requirements
Module: lsr_seq

Interface
REQ-001 Parameter: WIDTH, default 16, register width in bits (legal 2..64).
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1), derived amount/counter width.
REQ-003 clk  in  1  single clock; all state updates on falling edge of clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 clr  in  1  synchronous clear of out_r; aborts any sequence.
REQ-006 load  in  1  parallel load of in_A into out_r.
REQ-007 in_A  in  WIDTH  parallel load data.
REQ-008 start  in  1  begin multi-step shift of amount positions.
REQ-009 amount  in  CNT_W  shift count, sampled at start.
REQ-010 dir  in  1  0 = left, 1 = right; sampled at start.
REQ-011 arith  in  1  1 = right shift fills with MSB (sign); ignored for left; sampled at start.
REQ-012 shift  in  1  single-step logical left shift, zero fill.
REQ-013 load_R0  in  1  write in_bit into out_r[0], upper bits held.
REQ-014 in_bit  in  1  bit for load_R0.
REQ-015 out_r  out  WIDTH  register contents.
REQ-016 out_bit  out  1  last bit shifted out of out_r.
REQ-017 busy  out  1  high while a sequence runs.
REQ-018 done  out  1  one-cycle pulse at sequence completion.

Function
REQ-019 Idle command priority per edge: clr > load > start > shift > load_R0; lower commands ignored that edge.
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start with amount>0; IDLE->DONE on start with amount=0 (out_r unchanged).
REQ-021 In RUN: each edge shifts out_r one position per latched dir/arith, updates out_bit, decrements counter; after the Nth shift the FSM enters DONE.
REQ-022 DONE lasts exactly one cycle with done=1, then IDLE; busy=1 only in RUN.
REQ-023 amount > WIDTH clamps to WIDTH at start.
REQ-024 Latency: start accepted at edge k -> result on out_r after edge k+N, done high for the cycle after edge k+N.
REQ-025 While busy: load, start, shift, load_R0 ignored; clr clears out_r, out_bit, counter and returns to IDLE with no done pulse.
REQ-026 Single-step shift updates out_bit with old out_r[WIDTH-1].

Reset
REQ-027 reset low: out_r=0, out_bit=0, busy=0, done=0, FSM=IDLE, counter=0, immediately, independent of clk.
REQ-028 reset during RUN aborts the sequence; no done pulse after release.

Configuration
REQ-029 Macro LSR_SEQ_ROTATE_EN defined: extra input rot (1 bit, sampled at start); rot=1 re-inserts each shifted-out bit at the opposite end (arith ignored).
REQ-030 Macro undefined: no rot port; fill is zero (left, logical right) or sign (arithmetic right).

Structure
REQ-031 Package lsr_seq_pkg holds FSM state enum (IDLE, RUN, DONE) and direction constants DIR_LEFT=0, DIR_RIGHT=1.
REQ-032 Sub-module lsr_seq_ctrl contains FSM and down-counter and emits per-cycle step enable; datapath stays in lsr_seq.

Verification (WIDTH=16)
REQ-033 reset low mid-RUN -> out_r=0x0000, busy=0, done=0 at once; no done after release.
REQ-034 load 0x00F0; start dir=0 amount=4 -> busy 4 cycles, out_r=0x0F00, out_bit=0, done one cycle.
REQ-035 load 0x8004; start dir=1 arith=1 amount=2 -> out_r=0xE001, out_bit=0; amount=0 -> done next cycle, out_r unchanged.
REQ-036 load 0xFFFF; start dir=0 amount=20 -> clamped 16 steps, out_r=0x0000, out_bit=1; clr at step 5 -> out_r=0, busy=0, no done.
REQ-037 out_r=0x0003; shift -> 0x0006; load_R0 in_bit=1 -> 0x0007; load+shift same edge -> in_A loaded.
REQ-038 LSR_SEQ_ROTATE_EN: load 0x8001; start dir=0 rot=1 amount=1 -> out_r=0x0003, out_bit=1.
